// File: rtl/ray_stream_deserializer_pkg.sv
// Shared ray types for the ray word serializer/deserializer pair.
// A ray is packed orig first, then dir; each component is a 24-bit signed word.
package ray_stream_deserializer_pkg;

   localparam int VEC_W     = 24;
   localparam int RAY_WORDS = 6;

   typedef logic [2:0] ray_word_idx_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COLLECT  = 2'd1,
      WAIT_OUT = 2'd2,
      RESYNC   = 2'd3
   } ray_deser_state_e;

   typedef struct packed {
      logic signed [VEC_W-1:0] x;
      logic signed [VEC_W-1:0] y;
      logic signed [VEC_W-1:0] z;
   } vec3;

   typedef vec3 point;

   typedef struct packed {
      point orig;
      vec3  dir;
   } ray;

   localparam ray ray_default = '0;

endpackage

// File: rtl/ray_stream_deserializer_out_slot.sv
// One-entry valid/ready holding register for any packed struct type.
// A load in the same cycle as a drain keeps valid high with the new data.
module ray_out_slot
   import ray_stream_deserializer_pkg::*;
#(
   parameter type T = ray
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  T     load_data,
   output T     data,
   output logic valid,
   input  logic ready,
   output logic free,
   output logic drain
);

   // Caller must only assert load while free is high.
   assign free  = !valid || ready;
   assign drain = valid && ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ray_stream_deserializer.sv
// Collects six signed component words into one ray and offers it downstream.
// Optional framing check on in_last is enabled with `define RAY_FRAME_CHECK_EN.
module ray_stream_deserializer
   import ray_stream_deserializer_pkg::*;
#(
   parameter int DATA_W        = 24,
   parameter int WORDS_PER_RAY = 6,
   parameter int CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   output ray                out_ray,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  ray_count,
   output logic              frame_err
);

   localparam logic [1:0] ST_IDLE     = IDLE;
   localparam logic [1:0] ST_COLLECT  = COLLECT;
   localparam logic [1:0] ST_WAIT_OUT = WAIT_OUT;
   localparam logic [1:0] ST_RESYNC   = RESYNC;

   logic [1:0]          state;
   ray_word_idx_t       idx;
   logic                rdy_q;
   logic [CNT_W-1:0]    ray_count_q;
   logic                frame_err_q;
   logic signed [DATA_W-1:0] words      [WORDS_PER_RAY];
   logic signed [DATA_W-1:0] next_words [WORDS_PER_RAY];
   ray                  load_ray;
   logic                acc, collecting, take, at_last;
   logic                bad_early, bad_late;
   logic                load, slot_free, drain;

   // rdy_q keeps in_ready low while reset is held.
   assign in_ready   = rdy_q && (state != ST_WAIT_OUT);
   assign acc        = in_valid && in_ready;
   assign collecting = (state == ST_IDLE) || (state == ST_COLLECT);
   assign take       = acc && collecting;
   assign at_last    = (idx == ray_word_idx_t'(WORDS_PER_RAY-1));

`ifdef RAY_FRAME_CHECK_EN
   assign bad_early = in_last && !at_last;
   assign bad_late  = !in_last && at_last;
`else
   logic unused_last;
   assign unused_last = in_last;
   assign bad_early   = 1'b0;
   assign bad_late    = 1'b0;
`endif

   assign load = (take && at_last && !bad_late && slot_free) ||
                 ((state == ST_WAIT_OUT) && slot_free);

   always_comb begin
      next_words = words;
      if (take) next_words[idx] = in_data;
      load_ray        = ray_default;
      load_ray.orig.x = next_words[0];
      load_ray.orig.y = next_words[1];
      load_ray.orig.z = next_words[2];
      load_ray.dir.x  = next_words[3];
      load_ray.dir.y  = next_words[4];
      load_ray.dir.z  = next_words[5];
   end

   // Staging words are pure data; they are overwritten before each use.
   always_ff @(posedge clk) begin
      words <= next_words;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         idx         <= '0;
         rdy_q       <= 1'b0;
         ray_count_q <= '0;
         frame_err_q <= 1'b0;
      end else begin
         rdy_q       <= 1'b1;
         frame_err_q <= take && (bad_early || bad_late);
         if (drain) ray_count_q <= ray_count_q + CNT_W'(1);
         case (state)
            ST_IDLE, ST_COLLECT: begin
               if (take) begin
                  if (bad_early) begin
                     idx   <= '0;
                     state <= ST_IDLE;
                  end else if (at_last) begin
                     idx <= '0;
                     if (bad_late)       state <= ST_RESYNC;
                     else if (slot_free) state <= ST_IDLE;
                     else                state <= ST_WAIT_OUT;
                  end else begin
                     idx   <= idx + ray_word_idx_t'(1);
                     state <= ST_COLLECT;
                  end
               end
            end
            ST_WAIT_OUT: begin
               if (slot_free) state <= ST_IDLE;
            end
`ifdef RAY_FRAME_CHECK_EN
            ST_RESYNC: begin
               if (acc && in_last) state <= ST_IDLE;
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   ray_out_slot #(.T(ray)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (load_ray),
      .data      (out_ray),
      .valid     (out_valid),
      .ready     (out_ready),
      .free      (slot_free),
      .drain     (drain)
   );

   assign busy      = (state != ST_IDLE) || out_valid;
   assign ray_count = ray_count_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ray_stream_deserializer.sv
// Scoreboard bench: expected rays are queued by the driver, popped by a monitor.
// A second instance with a 2-bit counter exercises counter wrap-around cheaply.
`timescale 1ns/1ps
module tb_ray_stream_deserializer;
   import ray_stream_deserializer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b1;
   logic        in_ready, out_valid, busy, frame_err;
   ray          out_ray;
   logic [15:0] ray_count;

   logic        unused_in_ready_s, unused_out_valid_s, unused_busy_s, unused_frame_err_s;
   ray          unused_out_ray_s;
   logic [1:0]  ray_count_s;

   ray  exp_q[$];
   int  tests = 0;
   int  fails = 0;
   int  cyc = 0;
   int  stalls = 0;
   int  last_out = -1;
   bit  streaming = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ray_stream_deserializer dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .in_last(in_last), .out_ray(out_ray),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
      .ray_count(ray_count), .frame_err(frame_err)
   );

   ray_stream_deserializer #(.CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(unused_in_ready_s), .in_last(in_last), .out_ray(unused_out_ray_s),
      .out_valid(unused_out_valid_s), .out_ready(out_ready), .busy(unused_busy_s),
      .ray_count(ray_count_s), .frame_err(unused_frame_err_s)
   );

   task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic ray mk(input logic [23:0] a, b, c, d, e, f);
      ray r;
      r.orig.x = a; r.orig.y = b; r.orig.z = c;
      r.dir.x  = d; r.dir.y  = e; r.dir.z  = f;
      return r;
   endfunction

   // Inputs change on the falling edge; the monitor samples 1ns later.
   always begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ray: got %0h, required no output", out_ray);
         end else begin
            check("ray_data", 144'(out_ray), 144'(exp_q.pop_front()));
         end
         if (streaming) begin
            if (last_out >= 0) check("stream_period", 144'(cyc - last_out), 144'(6));
            last_out = cyc;
         end
      end
   end

   task automatic send_word(input logic [23:0] d, input logic l);
      int n;
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      n = 0;
      if (!in_ready) stalls++;
      while (!in_ready) begin
         @(negedge clk);
         n++;
         if (n > 100) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, required 1", n);
            break;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_ray(input logic [23:0] a, b, c, d, e, f, input ray exp);
      exp_q.push_back(exp);
      send_word(a, 1'b0);
      send_word(b, 1'b0);
      send_word(c, 1'b0);
      send_word(d, 1'b0);
      send_word(e, 1'b0);
      send_word(f, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      ray ra, rb, rn;
      idle(2);
      check("rst_in_ready", 144'(in_ready), 144'(0));
      check("rst_out_valid", 144'(out_valid), 144'(0));
      check("rst_busy", 144'(busy), 144'(0));
      check("rst_ray_count", 144'(ray_count), 144'(0));
      check("rst_out_ray", 144'(out_ray), 144'(0));
      check("rst_frame_err", 144'(frame_err), 144'(0));
      rst_n = 1'b1;
      idle(2);
      check("post_rst_in_ready", 144'(in_ready), 144'(1));

      // Basic assembly and latency
      send_ray(24'h000001, 24'h000002, 24'h000003, 24'h000004, 24'h000005, 24'h000006,
               mk(24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6));
      check("latency_out_valid", 144'(out_valid), 144'(1));
      idle(2);
      check("count_basic", 144'(ray_count), 144'(1));
      check("busy_idle", 144'(busy), 144'(0));

      // Negative / extreme values, expected values written as decimals
      rn.orig.x = 24'(-8388608); rn.orig.y = 24'(8388607); rn.orig.z = 24'(-1);
      rn.dir.x  = 24'(0);        rn.dir.y  = 24'(16);      rn.dir.z  = 24'(-16);
      send_ray(24'h800000, 24'h7FFFFF, 24'hFFFFFF, 24'h000000, 24'h000010, 24'hFFFFF0, rn);
      idle(2);
      check("count_neg", 144'(ray_count), 144'(2));

      // Back-pressure: two rays held, second waits in staging
      out_ready = 1'b0;
      ra = mk(24'h000101, 24'h000102, 24'h000103, 24'h000104, 24'h000105, 24'h000106);
      rb = mk(24'h000201, 24'h000202, 24'h000203, 24'h000204, 24'h000205, 24'h000206);
      send_ray(24'h000101, 24'h000102, 24'h000103, 24'h000104, 24'h000105, 24'h000106, ra);
      send_ray(24'h000201, 24'h000202, 24'h000203, 24'h000204, 24'h000205, 24'h000206, rb);
      check("wait_out_in_ready", 144'(in_ready), 144'(0));
      check("wait_out_busy", 144'(busy), 144'(1));
      check("hold_stable_a", 144'(out_ray), 144'(ra));
      idle(3);
      check("hold_stable_b", 144'(out_ray), 144'(ra));
      check("hold_valid", 144'(out_valid), 144'(1));
      out_ready = 1'b1;
      idle(1);
      check("reload_valid", 144'(out_valid), 144'(1));
      idle(1);
      check("drained_valid", 144'(out_valid), 144'(0));
      check("bp_in_ready", 144'(in_ready), 144'(1));
      idle(1);
      check("count_bp", 144'(ray_count), 144'(4));
      check("count_wrap_small", 144'(ray_count_s), 144'(0));

      // Streaming: ten rays back to back
      stalls    = 0;
      last_out  = -1;
      streaming = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         logic [23:0] b0;
         b0 = 24'(k * 16);
         send_ray(b0, b0 + 24'd1, b0 + 24'd2, b0 + 24'd3, b0 + 24'd4, b0 + 24'd5,
                  mk(b0, b0 + 24'd1, b0 + 24'd2, b0 + 24'd3, b0 + 24'd4, b0 + 24'd5));
      end
      idle(3);
      streaming = 1'b0;
      check("stream_stalls", 144'(stalls), 144'(0));
      check("count_stream", 144'(ray_count), 144'(14));
      check("count_small_stream", 144'(ray_count_s), 144'(2));

      // Reset mid-ray discards the partial ray
      send_word(24'h000AAA, 1'b0);
      send_word(24'h000BBB, 1'b0);
      send_word(24'h000CCC, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 144'(in_ready), 144'(0));
      check("midrst_busy", 144'(busy), 144'(0));
      check("midrst_count", 144'(ray_count), 144'(0));
      check("midrst_out_valid", 144'(out_valid), 144'(0));
      idle(2);
      rst_n = 1'b1;
      idle(2);
      send_ray(24'h000301, 24'h000302, 24'h000303, 24'h000304, 24'h000305, 24'h000306,
               mk(24'h000301, 24'h000302, 24'h000303, 24'h000304, 24'h000305, 24'h000306));
      idle(3);
      check("count_after_rst", 144'(ray_count), 144'(1));

`ifdef RAY_FRAME_CHECK_EN
      send_word(24'h000001, 1'b0);
      send_word(24'h000002, 1'b0);
      send_word(24'h000003, 1'b1);
      check("frame_err_early", 144'(frame_err), 144'(1));
      idle(1);
      check("frame_err_pulse", 144'(frame_err), 144'(0));
      check("frame_early_busy", 144'(busy), 144'(0));
      for (int i = 0; i < 6; i++) send_word(24'(i + 40), 1'b0);
      check("frame_err_late", 144'(frame_err), 144'(1));
      send_word(24'h000777, 1'b0);
      send_word(24'h000888, 1'b1);
      send_ray(24'h000401, 24'h000402, 24'h000403, 24'h000404, 24'h000405, 24'h000406,
               mk(24'h000401, 24'h000402, 24'h000403, 24'h000404, 24'h000405, 24'h000406));
      idle(3);
      check("count_after_frame", 144'(ray_count), 144'(2));
`endif

      check("queue_drained", 144'(exp_q.size()), 144'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
